// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and parity helper,
// used by both the transmitter and the receiver so their states decode the same way.
package uart_pkg;

   typedef enum logic [2:0] {
      s_IDLE   = 3'd0,
      s_START  = 3'd1,
      s_DATA   = 3'd2,
      s_PARITY = 3'd3,
      s_STOP   = 3'd4,
      s_DONE   = 3'd5
   } state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

   // Even parity: data plus this bit carries an even number of ones.
   function automatic logic even_parity(input logic [15:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side valid/ready word handshake into the UART transmitter.
interface uart_tx_if #(
   parameter int p_WORD_LEN = 8
);
   logic                  i_valid;
   logic [p_WORD_LEN-1:0] i_data;
   logic                  o_ready;

   modport master (output i_valid, output i_data, input  o_ready);
   modport slave  (input  i_valid, input  i_data, output o_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..p_CLK_DIV-1 and pulses o_tick on the last cycle of a bit.
module uart_baud_tick #(
   parameter int p_CLK_DIV = 104
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   output logic o_tick
);
   localparam int CW = (p_CLK_DIV > 2) ? $clog2(p_CLK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign o_tick = (cnt == CW'(p_CLK_DIV - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         cnt <= '0;
      else if (i_clr || o_tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit after the data bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int p_CLK_DIV  = 104,
   parameter int p_WORD_LEN = 8
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   uart_tx_if.slave bus,
   output logic     o_tx,
   output logic     o_done
);
   localparam int BW = $clog2(p_WORD_LEN + 1);

   state_t                state, state_nx;
   logic [p_WORD_LEN-1:0] shift, shift_nx;
   logic [BW-1:0]         bit_cnt, bit_cnt_nx;
   logic                  tx_nx;
   logic                  ready;
   logic                  clr;
   logic                  tick;

   uart_baud_tick #(.p_CLK_DIV(p_CLK_DIV)) u_tick (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (clr),
      .o_tick  (tick)
   );

   assign bus.o_ready = ready;

`ifdef UART_TX_PARITY_EN
   logic par;

   // Parity is taken at accept because the shift register is consumed during DATA.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         par <= 1'b0;
      else if (state == s_IDLE && bus.i_valid)
         par <= even_parity(16'(bus.i_data));
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= s_IDLE;
         shift   <= '0;
         bit_cnt <= '0;
         o_tx    <= LINE_IDLE;
      end else begin
         state   <= state_nx;
         shift   <= shift_nx;
         bit_cnt <= bit_cnt_nx;
         o_tx    <= tx_nx;
      end
   end

   // o_tx is the registered image of the current state's level, so the line
   // trails the state by one cycle and falls on the edge after accept.
   always_comb begin
      state_nx   = state;
      shift_nx   = shift;
      bit_cnt_nx = bit_cnt;
      tx_nx      = LINE_IDLE;
      ready      = 1'b0;
      o_done     = 1'b0;
      clr        = 1'b0;
      case (state)
         s_IDLE: begin
            ready      = 1'b1;
            clr        = 1'b1;
            bit_cnt_nx = '0;
            if (bus.i_valid) begin
               shift_nx = bus.i_data;
               state_nx = s_START;
            end
         end
         s_START: begin
            tx_nx = START_LVL;
            if (tick) state_nx = s_DATA;
         end
         s_DATA: begin
            tx_nx = shift[0];
            if (tick) begin
               shift_nx   = shift >> 1;
               bit_cnt_nx = bit_cnt + 1'b1;
               if (bit_cnt == BW'(p_WORD_LEN - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_nx = s_PARITY;
`else
                  state_nx = s_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         s_PARITY: begin
            tx_nx = par;
            if (tick) state_nx = s_STOP;
         end
`endif
         s_STOP: begin
            tx_nx = STOP_LVL;
            if (tick) state_nx = s_DONE;
         end
         s_DONE: begin
            o_done   = 1'b1;
            clr      = 1'b1;
            state_nx = s_IDLE;
         end
         default: begin
            clr      = 1'b1;
            state_nx = s_IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: random and directed words against a frame-level model.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
   localparam int WL = 7;
   localparam int P  = 1;
`else
   localparam int WL = 8;
   localparam int P  = 0;
`endif
   localparam int DIV = 4;
   localparam int NB  = WL + 2 + P;
   localparam int N   = NB * DIV;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic tx, done;
   int   vecs  = 0;
   int   errs  = 0;

   uart_tx_if #(.p_WORD_LEN(WL)) bus ();

   uart_tx #(.p_CLK_DIV(DIV), .p_WORD_LEN(WL)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus),
      .o_tx    (tx),
      .o_done  (done)
   );

   always #5 clk = ~clk;

   // Line level k cycles after the accept edge: idle, then each frame bit held DIV cycles.
   function automatic logic exp_tx(input logic [WL-1:0] w, input int k);
      logic [NB-1:0] fr;
      fr    = '0;
      fr[0] = 1'b0;
      for (int i = 0; i < WL; i++) fr[i+1] = w[i];
      if (P == 1) fr[WL+1] = ^w;
      fr[NB-1] = 1'b1;
      if (k < 1 || k > N) return 1'b1;
      return fr[(k-1)/DIV];
   endfunction

   task automatic wait_ready(input string nm);
      int t = 0;
      while (bus.o_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      vecs++;
      if (bus.o_ready !== 1'b1) begin
         errs++;
         $display("FAIL %s ready_timeout got %b want 1", nm, bus.o_ready);
      end
   endtask

   task automatic run_frame(input logic [WL-1:0] w, input int glitch_k, input string nm);
      @(negedge clk);
      wait_ready(nm);
      bus.i_valid = 1'b1;
      bus.i_data  = w;
      @(posedge clk);
      for (int k = 0; k <= N + 1; k++) begin
         @(negedge clk);
         bus.i_valid = (k == glitch_k);
         bus.i_data  = (k == glitch_k) ? ~w : WL'($urandom);
         vecs++;
         if (tx !== exp_tx(w, k)) begin
            errs++;
            $display("FAIL %s tx k=%0d got %b want %b", nm, k, tx, exp_tx(w, k));
         end
         vecs++;
         if (bus.o_ready !== (k == N + 1)) begin
            errs++;
            $display("FAIL %s ready k=%0d got %b want %b", nm, k, bus.o_ready, (k == N + 1));
         end
         vecs++;
         if (done !== (k == N)) begin
            errs++;
            $display("FAIL %s done k=%0d got %b want %b", nm, k, done, (k == N));
         end
      end
      bus.i_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      rst_n       = 1'b0;
      repeat (3) @(negedge clk);
      vecs++;
      if (tx !== 1'b1 || bus.o_ready !== 1'b1 || done !== 1'b0) begin
         errs++;
         $display("FAIL reset_hold tx/ready/done got %b%b%b want 110", tx, bus.o_ready, done);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         vecs++;
         if (tx !== 1'b1 || bus.o_ready !== 1'b1 || done !== 1'b0) begin
            errs++;
            $display("FAIL idle c=%0d tx/ready/done got %b%b%b want 110", c, tx, bus.o_ready, done);
         end
      end
   endtask

   task automatic test_single();
      run_frame(WL'(8'h55), -1, "send_55");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_frame(WL'($urandom), -1, "random");
      end
   endtask

   task automatic test_back_to_back();
      logic [WL-1:0] w1, w2;
      logic          e;
      w1 = WL'(8'hA3);
      w2 = WL'(8'h0F);
      @(negedge clk);
      wait_ready("b2b");
      bus.i_valid = 1'b1;
      bus.i_data  = w1;
      @(posedge clk);
      for (int k = 0; k <= 2*N + 3; k++) begin
         @(negedge clk);
         bus.i_data = w2;
         if (k == N + 2) bus.i_valid = 1'b0;
         e = (k <= N + 1) ? exp_tx(w1, k) : exp_tx(w2, k - (N + 2));
         vecs++;
         if (tx !== e) begin
            errs++;
            $display("FAIL b2b tx k=%0d got %b want %b", k, tx, e);
         end
         vecs++;
         if (done !== (k == N || k == 2*N + 2)) begin
            errs++;
            $display("FAIL b2b done k=%0d got %b want %b", k, done, (k == N || k == 2*N + 2));
         end
         vecs++;
         if (bus.o_ready !== (k == N + 1 || k == 2*N + 3)) begin
            errs++;
            $display("FAIL b2b ready k=%0d got %b want %b", k, bus.o_ready, (k == N + 1 || k == 2*N + 3));
         end
      end
      bus.i_valid = 1'b0;
   endtask

   task automatic test_ignore();
      run_frame(WL'(8'h00), 10, "ignore_ff");
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         vecs++;
         if (tx !== 1'b1 || done !== 1'b0 || bus.o_ready !== 1'b1) begin
            errs++;
            $display("FAIL ignore_after c=%0d tx/done/ready got %b%b%b want 101", c, tx, done, bus.o_ready);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [WL-1:0] w;
      w = WL'(8'hFF);
      @(negedge clk);
      wait_ready("rst_mid");
      bus.i_valid = 1'b1;
      bus.i_data  = w;
      @(posedge clk);
      // Land inside data bit 3 (frame bit index 4), where the line is low-to-high sensitive.
      repeat (1 + 4*DIV + 1) @(negedge clk);
      bus.i_valid = 1'b0;
      vecs++;
      if (tx !== 1'b1) begin
         errs++;
         $display("FAIL rst_mid pre tx got %b want 1", tx);
      end
      #1 rst_n = 1'b0;
      #1;
      vecs++;
      if (tx !== 1'b1 || bus.o_ready !== 1'b1 || done !== 1'b0) begin
         errs++;
         $display("FAIL rst_mid async tx/ready/done got %b%b%b want 110", tx, bus.o_ready, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < N + 4; c++) begin
         @(negedge clk);
         vecs++;
         if (done !== 1'b0 || tx !== 1'b1) begin
            errs++;
            $display("FAIL rst_mid after c=%0d done/tx got %b%b want 01", c, done, tx);
         end
      end
      run_frame(WL'(8'h81), -1, "after_rst_81");
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      run_frame(WL'(8'h07), -1, "par_07");
      run_frame(WL'(8'h03), -1, "par_03");
      // Direct look at the parity bit slot for both words.
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         wait_ready("par_slot");
         bus.i_valid = 1'b1;
         bus.i_data  = (j == 0) ? WL'(8'h07) : WL'(8'h03);
         @(posedge clk);
         @(negedge clk);
         bus.i_valid = 1'b0;
         repeat ((WL + 1)*DIV + 1) @(negedge clk);
         vecs++;
         if (tx !== ((j == 0) ? 1'b1 : 1'b0)) begin
            errs++;
            $display("FAIL par_slot j=%0d got %b want %b", j, tx, (j == 0));
         end
         repeat (N) @(negedge clk);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_random();
      test_back_to_back();
      test_ignore();
      test_reset_mid();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
